uart_tx_word: RTL and testbench

Parametrised multi-byte UART transmitter: accepts one word of DATA_BYTES bytes on a valid/ready handshake and serialises it as back-to-back 8-bit UART frames on a single pin. Optional parity, 1 or 2 stop bits, and selectable byte order. It runs entirely on the system clock with an internal baud-rate enable; it does not use a derived bit clock. It is the next-generation replacement for the fixed 2-byte transmitter in the PUF readout path.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 48 ++++
 rtl/uart_tx_word.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_word.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the word-oriented UART blocks. Both the transmitter
// and the future multi-byte receiver import this package. It provides:
//   - PARITY_NONE / PARITY_EVEN / PARITY_ODD : encodings of the PARITY parameter
//   - tx_state_t                             : transmitter state encoding
//   - frameBits()                            : line bits per byte (start + 8 data
//                                              + optional parity + stop bits)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_t;

    // Number of bit periods one byte occupies on the line. Multiply by the
    // baud divider to get clocks per byte.
    function automatic int frameBits(input int parity, input int stopBits);
        return 10 + ((parity != PARITY_NONE) ? 1 : 0) + (stopBits - 1);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
//
// Baud-rate enable generator. A free-running counter divides the system clock
// by CLK_DIV and flags the last clock of every bit period. The transmitter
// restarts it when a word is accepted, so the start bit is a full period long.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   restart  in   clear the counter so a new bit period begins next clock
//   tick     out  high on the final clock of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_badClkDiv
        $error("uart_baud_gen: CLK_DIV must be at least 2");
    end

    logic [CNT_W-1:0] r_count;

    // Counts 0..CLK_DIV-1 and wraps silently. A restart forces zero so the
    // following clock is the first clock of a fresh bit period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (restart) begin
            r_count <= '0;
        end else if (r_count == LAST_COUNT) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == LAST_COUNT);

endmodule

// File: rtl/uart_tx_word.sv
// ---------------------------------------------------------------------------
// uart_tx_word
//
// Multi-byte UART transmitter. One word of DATA_BYTES bytes is accepted on a
// valid/ready handshake and sent as back-to-back 8N1-style frames (optional
// parity, 1 or 2 stop bits). Byte order is selected by MSB_FIRST; bits within
// a byte always go LSB first. Everything runs on clk with a baud enable.
//
// Parameters:
//   CLK_DIV     system clocks per bit (>= 2)
//   DATA_BYTES  bytes per word (>= 1)
//   MSB_FIRST   1: most significant byte first, 0: least significant first
//   PARITY      0 none, 1 even, 2 odd
//   STOP_BITS   1 or 2
//
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   in_valid  in   word offered
//   in_ready  out  idle and able to accept (combinational from state)
//   in_data   in   word to send, sampled only at acceptance
//   tx_out    out  serial line, idles high
//   busy      out  high while a word is being sent
//   done      out  one-clock pulse as the block returns to idle
// ---------------------------------------------------------------------------
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int DATA_BYTES = 2,
    parameter int MSB_FIRST  = 1,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    done
);

    localparam int WORD_W     = 8 * DATA_BYTES;
    localparam int BYTE_CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(DATA_BYTES - 1);
    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    // Reject parameter combinations the datapath cannot represent.
    if (CLK_DIV < 2) begin : g_badClkDiv
        $error("uart_tx_word: CLK_DIV must be at least 2");
    end
    if (DATA_BYTES < 1) begin : g_badDataBytes
        $error("uart_tx_word: DATA_BYTES must be at least 1");
    end
    if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_badMsbFirst
        $error("uart_tx_word: MSB_FIRST must be 0 or 1");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_badParity
        $error("uart_tx_word: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_badStopBits
        $error("uart_tx_word: STOP_BITS must be 1 or 2");
    end

    tx_state_t r_state;
    tx_state_t w_nextState;

    logic [WORD_W-1:0]     r_shift;
    logic [WORD_W-1:0]     w_nextShift;
    logic [WORD_W-1:0]     w_shiftByByte;
    logic [BYTE_CNT_W-1:0] r_byteCnt;
    logic [BYTE_CNT_W-1:0] w_nextByteCnt;
    logic [2:0]            r_bitCnt;
    logic [2:0]            w_nextBitCnt;
    logic                  r_stopCnt;
    logic                  w_nextStopCnt;
    logic                  r_done;
    logic                  w_nextDone;

    logic [7:0] w_curByte;
    logic       w_parityBit;
    logic       w_accept;
    logic       w_tick;
    logic       w_txBit;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baudGen (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (w_accept),
        .tick    (w_tick)
    );

    // The byte on the line is always at the "outgoing" end of the shift
    // register; after each byte the register moves by 8 so the next byte
    // slides into that position.
    if (MSB_FIRST != 0) begin : g_msbFirst
        assign w_curByte     = r_shift[WORD_W-1 -: 8];
        assign w_shiftByByte = r_shift << 8;
    end else begin : g_lsbFirst
        assign w_curByte     = r_shift[7:0];
        assign w_shiftByByte = r_shift >> 8;
    end

    assign w_parityBit = (PARITY == PARITY_ODD) ? ~(^w_curByte) : (^w_curByte);

    // State and datapath registers. Reset abandons any partial frame and
    // suppresses done, leaving the line idle high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_byteCnt <= '0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_shift   <= w_nextShift;
            r_byteCnt <= w_nextByteCnt;
            r_bitCnt  <= w_nextBitCnt;
            r_stopCnt <= w_nextStopCnt;
            r_done    <= w_nextDone;
        end
    end

    // Next-state and line-level logic. Every transition out of a bit waits
    // for the baud tick, i.e. the last clock of that bit period. The step from
    // the final stop bit to the next start bit needs no idle gap, and done is
    // registered so it coincides with the first IDLE clock.
    always_comb begin
        w_nextState   = r_state;
        w_nextShift   = r_shift;
        w_nextByteCnt = r_byteCnt;
        w_nextBitCnt  = r_bitCnt;
        w_nextStopCnt = r_stopCnt;
        w_nextDone    = 1'b0;
        w_accept      = 1'b0;
        w_txBit       = 1'b1;

        case (r_state)
            TX_IDLE: begin
                w_txBit = 1'b1;
                if (in_valid) begin
                    w_accept      = 1'b1;
                    w_nextState   = TX_START;
                    w_nextShift   = in_data;
                    w_nextByteCnt = '0;
                    w_nextBitCnt  = '0;
                    w_nextStopCnt = 1'b0;
                end
            end

            TX_START: begin
                w_txBit = 1'b0;
                if (w_tick) begin
                    w_nextState  = TX_DATA;
                    w_nextBitCnt = '0;
                end
            end

            TX_DATA: begin
                w_txBit = w_curByte[r_bitCnt];
                if (w_tick) begin
                    if (r_bitCnt == 3'd7) begin
                        w_nextState   = HAS_PARITY ? TX_PAR : TX_STOP;
                        w_nextStopCnt = 1'b0;
                    end else begin
                        w_nextBitCnt = r_bitCnt + 3'd1;
                    end
                end
            end

            TX_PAR: begin
                w_txBit = w_parityBit;
                if (w_tick) begin
                    w_nextState   = TX_STOP;
                    w_nextStopCnt = 1'b0;
                end
            end

            TX_STOP: begin
                w_txBit = 1'b1;
                if (w_tick) begin
                    if (r_stopCnt == LAST_STOP) begin
                        if (r_byteCnt == LAST_BYTE) begin
                            w_nextState = TX_IDLE;
                            w_nextDone  = 1'b1;
                        end else begin
                            w_nextState   = TX_START;
                            w_nextByteCnt = r_byteCnt + BYTE_CNT_W'(1);
                            w_nextShift   = w_shiftByByte;
                        end
                    end else begin
                        w_nextStopCnt = r_stopCnt + 1'b1;
                    end
                end
            end

            default: begin
                w_nextState = TX_IDLE;
            end
        endcase
    end

    assign tx_out   = w_txBit;
    assign in_ready = (r_state == TX_IDLE);
    assign busy     = (r_state != TX_IDLE);
    assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_word.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_word
//
// Bench for uart_tx_word. Five instances cover the parameter corners: default
// framing, 4-byte LSB-first, even parity, odd parity with two stop bits, and
// the minimum bit period. A vector table drives single words; hand-written
// sequences cover back-to-back acceptance and reset in mid-frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_word;

    localparam int NDUT = 5;
    localparam int CAP  = 200;

    typedef struct {
        int          dut;
        int          clkDiv;
        int          nBytes;
        int          hasPar;
        int          nStop;
        logic [31:0] word;
        logic [31:0] expBytes;
        logic [3:0]  expPar;
        int          expClocks;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        inValid [NDUT];
    logic [31:0] inData  [NDUT];
    logic        inReady [NDUT];
    logic        txOut   [NDUT];
    logic        busy    [NDUT];
    logic        done    [NDUT];

    logic capTx    [0:CAP-1];
    logic capDone  [0:CAP-1];
    logic capBusy  [0:CAP-1];
    logic capReady [0:CAP-1];

    int checks;
    int fails;

    vec_t vecs [10];

    // Shared system clock for every instance.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_word #(.CLK_DIV(4), .DATA_BYTES(2), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0][15:0]), .tx_out(txOut[0]), .busy(busy[0]), .done(done[0]));

    uart_tx_word #(.CLK_DIV(4), .DATA_BYTES(4), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1]), .tx_out(txOut[1]), .busy(busy[1]), .done(done[1]));

    uart_tx_word #(.CLK_DIV(4), .DATA_BYTES(1), .MSB_FIRST(1), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data(inData[2][7:0]), .tx_out(txOut[2]), .busy(busy[2]), .done(done[2]));

    uart_tx_word #(.CLK_DIV(4), .DATA_BYTES(1), .MSB_FIRST(1), .PARITY(2), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
        .in_data(inData[3][7:0]), .tx_out(txOut[3]), .busy(busy[3]), .done(done[3]));

    uart_tx_word #(.CLK_DIV(2), .DATA_BYTES(1), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(inValid[4]), .in_ready(inReady[4]),
        .in_data(inData[4][7:0]), .tx_out(txOut[4]), .busy(busy[4]), .done(done[4]));

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Records n consecutive falling-edge samples of one instance, starting at
    // the current falling edge, into the capture arrays at offset base.
    task automatic captureLine(input int d, input int n, input int base);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            capTx[base+k]    = txOut[d];
            capDone[base+k]  = done[d];
            capBusy[base+k]  = busy[d];
            capReady[base+k] = inReady[d];
        end
    endtask

    // Offers one word and captures the line from the first clock after the
    // acceptance edge (capture index 0) through a few idle clocks.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        checkVal("readyBeforeSend", {31'b0, inReady[v.dut]}, 32'd1);
        inData[v.dut]  = v.word;
        inValid[v.dut] = 1'b1;
        @(negedge clk);
        inValid[v.dut] = 1'b0;
        captureLine(v.dut, v.expClocks + 3, 0);
    endtask

    // Decodes the captured line for one word starting at capture index base
    // and compares every field against the record.
    task automatic checkOutput(input vec_t v, input int base);
        int fb;
        int half;
        int pos;
        int doneCnt;
        int busyLow;
        logic [7:0] got;
        logic unstable;
        fb   = 10 + v.hasPar + v.nStop - 1;
        half = v.clkDiv / 2;
        for (int b = 0; b < v.nBytes; b++) begin
            pos = base + b * fb * v.clkDiv;
            checkVal($sformatf("startBit[%0d]", b), {31'b0, capTx[pos+half]}, 32'd0);
            for (int j = 0; j < 8; j++) got[j] = capTx[pos + (1 + j) * v.clkDiv + half];
            checkVal($sformatf("dataByte[%0d]", b), {24'b0, got}, {24'b0, v.expBytes[8*b +: 8]});
            if (v.hasPar != 0)
                checkVal($sformatf("parityBit[%0d]", b), {31'b0, capTx[pos + 9 * v.clkDiv + half]},
                         {31'b0, v.expPar[b]});
            for (int s = 0; s < v.nStop; s++)
                checkVal($sformatf("stopBit[%0d.%0d]", b, s),
                         {31'b0, capTx[pos + (9 + v.hasPar + s) * v.clkDiv + half]}, 32'd1);
            unstable = 1'b0;
            for (int k = 0; k < fb; k++)
                for (int c = 0; c < v.clkDiv; c++)
                    if (capTx[pos + k * v.clkDiv + c] !== capTx[pos + k * v.clkDiv]) unstable = 1'b1;
            checkVal($sformatf("bitStable[%0d]", b), {31'b0, unstable}, 32'd0);
        end
        doneCnt = 0;
        busyLow = 0;
        for (int k = base; k <= base + v.expClocks; k++) if (capDone[k] === 1'b1) doneCnt++;
        for (int k = base; k < base + v.expClocks; k++) if (capBusy[k] !== 1'b1) busyLow++;
        checkVal("doneAtEnd",   {31'b0, capDone[base + v.expClocks]},  32'd1);
        checkVal("doneCount",   doneCnt, 32'd1);
        checkVal("busyInFrame", busyLow, 32'd0);
        checkVal("busyAtEnd",   {31'b0, capBusy[base + v.expClocks]},  32'd0);
        checkVal("readyAtEnd",  {31'b0, capReady[base + v.expClocks]}, 32'd1);
        checkVal("idleLine",    {31'b0, capTx[base + v.expClocks]},    32'd1);
    endtask

    initial begin
        vec_t v1;
        vec_t v2;
        int doneSeen;
        int lineLow;

        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            inValid[d] = 1'b0;
            inData[d]  = 32'h0;
        end

        //            dut div bytes par stop word           expBytes       par   clocks
        vecs[0] = '{0, 4, 2, 0, 1, 32'h0000A55A, 32'h00005AA5, 4'h0,  80};
        vecs[1] = '{0, 4, 2, 0, 1, 32'h00001234, 32'h00003412, 4'h0,  80};
        vecs[2] = '{1, 4, 4, 0, 1, 32'h04030201, 32'h04030201, 4'h0, 160};
        vecs[3] = '{1, 4, 4, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 4'h0, 160};
        vecs[4] = '{2, 4, 1, 1, 1, 32'h00000007, 32'h00000007, 4'h1,  44};
        vecs[5] = '{2, 4, 1, 1, 1, 32'h00000003, 32'h00000003, 4'h0,  44};
        vecs[6] = '{3, 4, 1, 1, 2, 32'h00000007, 32'h00000007, 4'h0,  48};
        vecs[7] = '{3, 4, 1, 1, 2, 32'h00000000, 32'h00000000, 4'h1,  48};
        vecs[8] = '{4, 2, 1, 0, 1, 32'h000000C3, 32'h000000C3, 4'h0,  20};
        vecs[9] = '{4, 2, 1, 0, 1, 32'h00000081, 32'h00000081, 4'h0,  20};

        // Reset values on every instance while reset is held.
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checkVal($sformatf("resetTx[%0d]", d),    {31'b0, txOut[d]},   32'd1);
            checkVal($sformatf("resetBusy[%0d]", d),  {31'b0, busy[d]},    32'd0);
            checkVal($sformatf("resetDone[%0d]", d),  {31'b0, done[d]},    32'd0);
            checkVal($sformatf("resetReady[%0d]", d), {31'b0, inReady[d]}, 32'd1);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], 0);
        end

        // Back-to-back: in_valid toggles with junk mid-frame, then a new word
        // is held in the done cycle (capture index 80) and must start at 81.
        $display("[TB] back-to-back");
        v1 = '{0, 4, 2, 0, 1, 32'h00001234, 32'h00003412, 4'h0, 80};
        v2 = '{0, 4, 2, 0, 1, 32'h0000BEEF, 32'h0000EFBE, 4'h0, 80};
        @(negedge clk);
        inData[0]  = 32'h1234;
        inValid[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        for (int k = 0; k < 164; k++) begin
            if (k > 0) @(negedge clk);
            capTx[k]    = txOut[0];
            capDone[k]  = done[0];
            capBusy[k]  = busy[0];
            capReady[k] = inReady[0];
            if (k >= 6 && k <= 60) begin
                inValid[0] = k[0];
                inData[0]  = k[0] ? 32'hFFFF : 32'h0000;
            end
            if (k == 61) inValid[0] = 1'b0;
            if (k == 79) begin
                inData[0]  = 32'hBEEF;
                inValid[0] = 1'b1;
            end
            if (k == 81) inValid[0] = 1'b0;
        end
        checkVal("b2bReadyInDone", {31'b0, capReady[80]}, 32'd1);
        checkVal("b2bStartNext",   {31'b0, capTx[81]},    32'd0);
        checkOutput(v1, 0);
        checkOutput(v2, 81);

        // Reset pulsed during the data bits of the first byte.
        $display("[TB] reset mid-frame");
        @(negedge clk);
        inData[0]  = 32'hA55A;
        inValid[0] = 1'b1;
        @(negedge clk);
        inValid[0] = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkVal("midResetTx",    {31'b0, txOut[0]},   32'd1);
        checkVal("midResetBusy",  {31'b0, busy[0]},    32'd0);
        checkVal("midResetReady", {31'b0, inReady[0]}, 32'd1);
        doneSeen = 0;
        lineLow  = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 3) reset_n = 1'b1;
            if (done[0] !== 1'b0) doneSeen++;
            if (txOut[0] !== 1'b1) lineLow++;
        end
        checkVal("midResetNoDone", doneSeen, 32'd0);
        checkVal("midResetIdle",   lineLow,  32'd0);
        v1 = '{0, 4, 2, 0, 1, 32'h0000C33C, 32'h00003CC3, 4'h0, 80};
        applyStimulus(v1);
        checkOutput(v1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
